// File: rtl/s247_core_dispatcher.sv
// s247_core_dispatcher
// Initiator-side driver for one s247 compute core. Takes GPS fixes from a
// valid/ready stream, hands each fix plus the latched geofence to the core,
// pulses core_enable, waits for done/halt (with a timeout) and emits a tagged
// verdict. Breach and timeout status are held in sticky flags.
module s247_core_dispatcher #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int STOP_ON_BREACH = 1,
    parameter int SEQ_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_lat,
    input  logic [DATA_WIDTH-1:0] s_lon,
    input  logic                  cfg_load,
    input  logic [DATA_WIDTH-1:0] cfg_lat,
    input  logic [DATA_WIDTH-1:0] cfg_lon,
    input  logic [DATA_WIDTH-1:0] cfg_rad,
    output logic                  core_enable,
    output logic [DATA_WIDTH-1:0] core_gps_lat,
    output logic [DATA_WIDTH-1:0] core_gps_lon,
    output logic [DATA_WIDTH-1:0] core_fence_lat,
    output logic [DATA_WIDTH-1:0] core_fence_lon,
    output logic [DATA_WIDTH-1:0] core_fence_rad,
    input  logic [DATA_WIDTH-1:0] core_result,
    input  logic                  core_done,
    input  logic                  core_halt,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_result,
    output logic                  m_inside,
    output logic [SEQ_WIDTH-1:0]  m_seq,
    output logic                  breach_irq,
    input  logic                  breach_clr,
    output logic                  err_timeout
);

    // Q16.16 value 1.0: the core's "inside" answer
    localparam logic [DATA_WIDTH-1:0] ONE_Q = DATA_WIDTH'(32'h0001_0000);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        OUTPUT = 3'd3,
        LOCKED = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] lat_q, lat_d, lon_q, lon_d;
    logic [DATA_WIDTH-1:0] flat_q, flat_d, flon_q, flon_d, frad_q, frad_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  halt_seen_q, halt_seen_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  inside_q, inside_d;
    logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
    logic                  breach_q, breach_d;
    logic                  err_q, err_d;

    // State register and datapath registers; reset clears everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            lon_q       <= '0;
            flat_q      <= '0;
            flon_q      <= '0;
            frad_q      <= '0;
            timer_q     <= '0;
            halt_seen_q <= 1'b0;
            res_q       <= '0;
            inside_q    <= 1'b0;
            seq_q       <= '0;
            breach_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            lon_q       <= lon_d;
            flat_q      <= flat_d;
            flon_q      <= flon_d;
            frad_q      <= frad_d;
            timer_q     <= timer_d;
            halt_seen_q <= halt_seen_d;
            res_q       <= res_d;
            inside_q    <= inside_d;
            seq_q       <= seq_d;
            breach_q    <= breach_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic: sequencing of one fix through the core
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        lon_d       = lon_q;
        flat_d      = flat_q;
        flon_d      = flon_q;
        frad_d      = frad_q;
        timer_d     = timer_q;
        halt_seen_d = halt_seen_q;
        res_d       = res_q;
        inside_d    = inside_q;
        seq_d       = seq_q;
        err_d       = err_q;
        // A clear in any state drops the flag; a same-cycle set below overrides it
        breach_d    = breach_clr ? 1'b0 : breach_q;

        case (state_q)
            IDLE: begin
                // Fence load and fix accept may coincide: the fix sees the new fence
                if (cfg_load) begin
                    flat_d = cfg_lat;
                    flon_d = cfg_lon;
                    frad_d = cfg_rad;
                end
                if (s_valid) begin
                    lat_d   = s_lat;
                    lon_d   = s_lon;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d     = '0;
                halt_seen_d = 1'b0;
                state_d     = WAIT;
            end
            WAIT: begin
                timer_d     = timer_q + 1'b1;
                halt_seen_d = halt_seen_q | core_halt;
                // Completion has priority over a timeout landing on the same cycle
                if (core_done) begin
                    res_d    = core_result;
                    inside_d = (core_result == ONE_Q) && !halt_seen_q && !core_halt;
                    state_d  = OUTPUT;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            OUTPUT: begin
                if (m_ready) begin
                    seq_d = seq_q + 1'b1;
                    if (!inside_q) begin
                        breach_d = 1'b1;
                        state_d  = (STOP_ON_BREACH != 0) ? LOCKED : IDLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LOCKED: begin
                if (cfg_load) begin
                    flat_d = cfg_lat;
                    flon_d = cfg_lon;
                    frad_d = cfg_rad;
                end
                if (breach_clr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is masked by reset so every output reads 0 while rst_n is low
    assign s_ready        = (state_q == IDLE) && rst_n;
    assign core_enable    = (state_q == ISSUE);
    assign m_valid        = (state_q == OUTPUT);
    assign core_gps_lat   = lat_q;
    assign core_gps_lon   = lon_q;
    assign core_fence_lat = flat_q;
    assign core_fence_lon = flon_q;
    assign core_fence_rad = frad_q;
    assign m_result       = res_q;
    assign m_inside       = inside_q;
    assign m_seq          = seq_q;
    assign breach_irq     = breach_q;
    assign err_timeout    = err_q;

endmodule

// File: tb/tb_s247_core_dispatcher.sv
// Bench for s247_core_dispatcher: behavioural core model, verdict scoreboard
// and directed scenarios with literal expectations.
module tb_s247_core_dispatcher;

    localparam int DW = 32;
    localparam int TO = 8;
    localparam int SW = 4;
    localparam logic [31:0] ONE = 32'h0001_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          s_valid = 1'b0, s_ready;
    logic [DW-1:0] s_lat = '0, s_lon = '0;
    logic          cfg_load = 1'b0;
    logic [DW-1:0] cfg_lat = '0, cfg_lon = '0, cfg_rad = '0;
    logic          core_enable;
    logic [DW-1:0] core_gps_lat, core_gps_lon;
    logic [DW-1:0] core_fence_lat, core_fence_lon, core_fence_rad;
    logic [DW-1:0] core_result = '0;
    logic          core_done = 1'b0, core_halt = 1'b0;
    logic          m_valid, m_ready = 1'b1;
    logic [DW-1:0] m_result;
    logic          m_inside;
    logic [SW-1:0] m_seq;
    logic          breach_irq, breach_clr = 1'b0, err_timeout;

    s247_core_dispatcher #(
        .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .STOP_ON_BREACH(1), .SEQ_WIDTH(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_lat(s_lat), .s_lon(s_lon),
        .cfg_load(cfg_load), .cfg_lat(cfg_lat), .cfg_lon(cfg_lon), .cfg_rad(cfg_rad),
        .core_enable(core_enable),
        .core_gps_lat(core_gps_lat), .core_gps_lon(core_gps_lon),
        .core_fence_lat(core_fence_lat), .core_fence_lon(core_fence_lon),
        .core_fence_rad(core_fence_rad),
        .core_result(core_result), .core_done(core_done), .core_halt(core_halt),
        .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result),
        .m_inside(m_inside), .m_seq(m_seq),
        .breach_irq(breach_irq), .breach_clr(breach_clr), .err_timeout(err_timeout)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Core model knobs, set by the directed sequence
    int          core_lat   = 4;
    logic [31:0] core_ret   = ONE;
    int          halt_mode  = 0;   // 0 none, 1 halt with done, 2 halt on first wait cycle
    bit          never_done = 1'b0;
    bit          spur       = 1'b0;

    // Scoreboard state
    typedef struct { logic [31:0] res; logic ins; } vexp_t;
    vexp_t       q[$];
    int          n_acc = 0;
    bit          mb = 1'b0;
    bit          prev_acc = 1'b0;
    bit          real_done = 1'b0;
    int          cnt = 0;
    logic [31:0] fix_lat = '0, fix_lon = '0;
    logic [31:0] ef_lat = '0, ef_lon = '0, ef_rad = '0;

    // Compare process plus core model, all on the falling edge
    always @(negedge clk) begin
        bit set_b;
        set_b = 1'b0;
        if (!rst_n) begin
            cnt = 0; core_done = 1'b0; core_halt = 1'b0; real_done = 1'b0;
            prev_acc = 1'b0; q.delete(); mb = 1'b0; n_acc = 0;
        end else begin
            if (prev_acc) begin
                chk("accept_to_enable", core_enable, 1);
                chk("gps_lat", core_gps_lat, fix_lat);
                chk("gps_lon", core_gps_lon, fix_lon);
                chk("fence_lat", core_fence_lat, ef_lat);
                chk("fence_lon", core_fence_lon, ef_lon);
                chk("fence_rad", core_fence_rad, ef_rad);
            end
            if (real_done) chk("done_to_valid", m_valid, 1);
            if (m_valid) begin
                if (q.size() == 0) begin
                    chk("verdict_pending", m_valid, 0);
                end else begin
                    chk("m_result", m_result, q[0].res);
                    chk("m_inside", m_inside, q[0].ins);
                    chk("m_seq", m_seq, n_acc % (1 << SW));
                    if (m_ready) begin
                        if (!q[0].ins) set_b = 1'b1;
                        void'(q.pop_front());
                        n_acc++;
                    end
                end
            end
            chk("ready_and_valid_exclusive", s_ready & m_valid, 0);
            chk("breach_irq", breach_irq, mb);
            if (breach_clr) mb = 1'b0;
            if (set_b) mb = 1'b1;
            prev_acc = s_valid && s_ready;

            real_done = 1'b0; core_done = 1'b0; core_halt = 1'b0;
            if (core_enable) begin
                cnt = core_lat;
            end else if (cnt > 0) begin
                cnt--;
                if (halt_mode == 2 && cnt == core_lat - 1) core_halt = 1'b1;
                if (cnt == 0 && !never_done) begin
                    core_done = 1'b1;
                    core_result = core_ret;
                    if (halt_mode == 1) core_halt = 1'b1;
                    q.push_back('{res: core_ret, ins: (core_ret == ONE) && (halt_mode == 0)});
                    real_done = 1'b1;
                end
            end
            if (spur) begin
                core_done = 1'b1; core_halt = 1'b1; core_result = ONE;
            end
        end
    end

    task automatic send_fix(input logic [31:0] la, input logic [31:0] lo, input bit ld,
                            input logic [31:0] fl, input logic [31:0] fo, input logic [31:0] fr);
        int b;
        b = 0;
        @(posedge clk); #1;
        while (!s_ready && b < 300) begin @(posedge clk); #1; b++; end
        if (!s_ready) chk("s_ready_wait", s_ready, 1);
        fix_lat = la; fix_lon = lo;
        s_valid = 1'b1; s_lat = la; s_lon = lo;
        if (ld) begin
            cfg_load = 1'b1; cfg_lat = fl; cfg_lon = fo; cfg_rad = fr;
            ef_lat = fl; ef_lon = fo; ef_rad = fr;
        end
        @(posedge clk); #1;
        s_valid = 1'b0; cfg_load = 1'b0;
    endtask

    task automatic fix(input logic [31:0] la, input logic [31:0] lo);
        send_fix(la, lo, 1'b0, '0, '0, '0);
    endtask

    task automatic wait_verdict(output int n);
        bit found;
        found = 1'b0; n = 0;
        while (!found && n < 50) begin
            @(negedge clk); n++;
            if (m_valid) found = 1'b1;
        end
        if (!found) chk("verdict_wait", m_valid, 1);
    endtask

    task automatic load_fence(input logic [31:0] fl, input logic [31:0] fo, input logic [31:0] fr);
        @(posedge clk); #1;
        cfg_load = 1'b1; cfg_lat = fl; cfg_lon = fo; cfg_rad = fr;
        @(posedge clk); #1;
        cfg_load = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_core_enable"}, core_enable, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_result"}, m_result, 0);
        chk({tag, "_m_inside"}, m_inside, 0);
        chk({tag, "_m_seq"}, m_seq, 0);
        chk({tag, "_breach"}, breach_irq, 0);
        chk({tag, "_err"}, err_timeout, 0);
        chk({tag, "_fence"}, {core_fence_lat, core_fence_lon}, 0);
        chk({tag, "_fence_rad"}, core_fence_rad, 0);
        chk({tag, "_gps"}, {core_gps_lat, core_gps_lon}, 0);
    endtask

    initial begin
        int n;
        logic [31:0] held;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", s_ready, 1);

        // Inside verdict with fence (0,0,2.0) and fix (1.0,0)
        load_fence(32'h0, 32'h0, 32'h0002_0000);
        ef_rad = 32'h0002_0000;
        @(negedge clk);
        chk("fence_rad_loaded", core_fence_rad, 32'h0002_0000);
        fix(ONE, 32'h0);
        wait_verdict(n);
        chk("fix_to_verdict_cycles", n, 6);
        chk("first_result", m_result, 32'h0001_0000);
        chk("first_inside", m_inside, 1);
        chk("first_seq", m_seq, 0);
        chk("first_breach", breach_irq, 0);

        // Breach: result 0 with halt -> lock until breach_clr
        core_ret = 32'h0; halt_mode = 1;
        fix(32'h0003_0000, 32'h0001_8000);
        wait_verdict(n);
        chk("breach_inside", m_inside, 0);
        @(negedge clk);
        chk("breach_set", breach_irq, 1);
        chk("locked_ready", s_ready, 0);
        load_fence(32'h0003_0000, 32'h0004_0000, 32'h0005_0000);
        ef_lat = 32'h0003_0000; ef_lon = 32'h0004_0000; ef_rad = 32'h0005_0000;
        @(negedge clk);
        chk("locked_fence_load", {core_fence_lat, core_fence_rad}, {32'h0003_0000, 32'h0005_0000});
        chk("still_locked", s_ready, 0);
        @(posedge clk); #1 breach_clr = 1'b1;
        @(posedge clk); #1 breach_clr = 1'b0;
        @(negedge clk);
        chk("unlock_ready", s_ready, 1);
        chk("unlock_breach", breach_irq, 0);

        // Halt seen early in WAIT, result 1.0, m_ready held low, then set+clear together
        core_ret = ONE; halt_mode = 2; m_ready = 1'b0;
        fix(32'h0000_8000, 32'h0000_4000);
        wait_verdict(n);
        held = m_result;
        chk("early_halt_inside", m_inside, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", m_valid, 1);
            chk("stall_result", m_result, held);
            chk("stall_ready", s_ready, 0);
            chk("stall_enable", core_enable, 0);
        end
        @(posedge clk); #1 breach_clr = 1'b1; m_ready = 1'b1;
        @(posedge clk); #1 breach_clr = 1'b0;
        @(negedge clk);
        chk("set_wins_breach", breach_irq, 1);
        chk("set_wins_locked", s_ready, 0);
        @(posedge clk); #1 breach_clr = 1'b1;
        @(posedge clk); #1 breach_clr = 1'b0;
        @(negedge clk);
        chk("unlock2_ready", s_ready, 1);

        // Fence load coinciding with fix accept applies to that fix
        halt_mode = 0;
        send_fix(32'h0000_5000, 32'h0000_6000, 1'b1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003);
        wait_verdict(n);
        chk("coload_inside", m_inside, 1);

        // Fence load during WAIT is ignored
        fix(32'h0000_7000, 32'h0000_7000);
        @(posedge clk); #1;
        cfg_load = 1'b1; cfg_lat = 32'hAAAA_0000; cfg_lon = 32'hBBBB_0000; cfg_rad = 32'hCCCC_0000;
        @(posedge clk); #1 cfg_load = 1'b0;
        @(negedge clk);
        chk("wait_load_ignored", {core_fence_lat, core_fence_lon, core_fence_rad} == {ef_lat, ef_lon, ef_rad}, 1);
        chk("wait_load_rad", core_fence_rad, 32'h0000_0003);
        wait_verdict(n);

        // Done on the last allowed WAIT cycle wins over timeout
        core_lat = TO;
        fix(32'h0000_1000, 32'h0000_2000);
        wait_verdict(n);
        chk("late_done_inside", m_inside, 1);
        @(negedge clk);
        chk("late_done_no_err", err_timeout, 0);

        // Timeout: core never completes
        never_done = 1'b1;
        fix(32'h0000_1111, 32'h0000_2222);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) chk("to_enable", core_enable, 1);
            if (i == 9) chk("to_err_before", err_timeout, 0);
            if (i == 10) begin
                chk("to_err_set", err_timeout, 1);
                chk("to_ready", s_ready, 1);
                chk("to_no_valid", m_valid, 0);
            end
        end
        never_done = 1'b0; core_lat = 4;

        // Spurious done/halt while IDLE are ignored
        @(posedge clk); #1 spur = 1'b1;
        @(posedge clk); #1 spur = 1'b0;
        @(negedge clk);
        chk("spur_no_valid", m_valid, 0);
        chk("spur_ready", s_ready, 1);

        // Next fix processed, sequence unchanged by the dropped fix
        fix(32'h0000_3333, 32'h0000_4444);
        wait_verdict(n);
        chk("after_to_seq", m_seq, 6);
        chk("after_to_err_sticky", err_timeout, 1);

        // Sequence wrap: 17th verdict carries tag 0
        @(posedge clk); #1;
        while (n_acc < 16) begin
            fix(32'h0000_0100, 32'h0000_0200);
            wait_verdict(n);
            @(posedge clk); #1;
        end
        fix(32'h0000_0300, 32'h0000_0400);
        wait_verdict(n);
        chk("seq_wrap", m_seq, 0);

        // Reset during WAIT
        fix(32'h0000_0500, 32'h0000_0600);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check_zero("midreset");
        @(posedge clk); #1 rst_n = 1'b1;
        ef_lat = '0; ef_lon = '0; ef_rad = '0;
        fix(ONE, 32'h0);
        wait_verdict(n);
        chk("post_reset_seq", m_seq, 0);
        chk("post_reset_inside", m_inside, 1);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
